// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared types and operand-sign helpers for the RV32M mul/div unit
package muldiv_sequencer_pkg;

  // Encoded as funct3 of the M extension so the decoder can pass it straight through.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } MulDivOp;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } MulDivState;

  function automatic logic op_is_div(input MulDivOp op);
    return op[2];
  endfunction

  function automatic logic op_a_signed(input MulDivOp op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input MulDivOp op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shift-add / restoring-divide accumulators with sign fixup and result register
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            fixup,
  input  logic            special_load,
  input  logic [XLEN-1:0] special_value,
  input  MulDivOp         op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] result
);

  MulDivOp         op_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q;     // multiplier shifting out / quotient shifting in
  logic            neg_q;

  logic            sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_value;

  always_comb begin
    sa    = op_a_signed(op) & in_a[XLEN-1];
    sb    = op_b_signed(op) & in_b[XLEN-1];
    abs_a = sa ? -in_a : in_a;
    abs_b = sb ? -in_b : in_b;
  end

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
  end

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                  fix_value = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:                fix_value = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:         fix_value = quo_fix;
      default:                 fix_value = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= OP_MUL;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      result <= '0;
    end else if (special_load) begin
      result <= special_value;
    end else if (load) begin
      op_q   <= op;
      opnd_q <= op_is_div(op) ? abs_b : abs_a;
      lo_q   <= op_is_div(op) ? abs_a : abs_b;
      hi_q   <= '0;
      // Remainder takes the dividend's sign; quotient and products take sa^sb.
      neg_q  <= (op == OP_REM) ? sa : (sa ^ sb);
    end else if (step) begin
      if (op_is_div(op_q)) begin
        hi_q <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end else if (fixup) begin
      result <= fix_value;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - FSM, iteration counter and special-case decode for the iterative mul/div unit
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  MulDivOp         op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  MulDivState state, next_state;
  logic [CNT_W-1:0] count, count_next;
  logic accept, load, step, fixup, special_load;
  logic div_by_zero, overflow, special;
  logic [XLEN-1:0] special_value;

  // op[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    div_by_zero = op_is_div(op) && (in_b == '0);
    overflow    = ((op == OP_DIV) || (op == OP_REM)) &&
                  (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    special     = div_by_zero || overflow;
    if (div_by_zero)
      special_value = op[1] ? in_a : '1;
    else
      special_value = op[1] ? '0 : in_a;
  end

  always_comb begin
    next_state   = state;
    count_next   = count;
    load         = 1'b0;
    step         = 1'b0;
    fixup        = 1'b0;
    special_load = 1'b0;
    accept       = start && ((state == ST_IDLE) || (state == ST_DONE)) && !flush;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (special) begin
            next_state   = ST_DONE;
            special_load = 1'b1;
          end else begin
            next_state = ST_CALC;
            load       = 1'b1;
            count_next = '0;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_CALC: begin
        step       = 1'b1;
        count_next = count + CNT_W'(1);
        if (count == CNT_W'(XLEN-1))
          next_state = ST_FIXUP;
      end
      ST_FIXUP: begin
        fixup      = 1'b1;
        next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (flush) begin
      next_state   = ST_IDLE;
      step         = 1'b0;
      fixup        = 1'b0;
    end
    stall = accept || (state == ST_CALC) || (state == ST_FIXUP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= next_state;
      count        <= count_next;
      busy         <= (next_state == ST_CALC) || (next_state == ST_FIXUP);
      result_valid <= (next_state == ST_DONE);
    end
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (load),
    .step          (step),
    .fixup         (fixup),
    .special_load  (special_load),
    .special_value (special_value),
    .op            (op),
    .in_a          (in_a),
    .in_b          (in_b),
    .result        (result)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - table-driven and sequence checks for muldiv_sequencer
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  MulDivOp     op;
  logic [31:0] in_a, in_b;
  logic        flush;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  int n_pass = 0;
  int n_total = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .op           (op),
    .in_a         (in_a),
    .in_b         (in_b),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    MulDivOp     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  // Called at posedge+1 with inputs idle; returns edges to result_valid and stall-high cycles.
  task automatic do_op(input MulDivOp o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stalls, output logic [31:0] res);
    op = o; in_a = a; in_b = b; start = 1'b1;
    lat = 0; stalls = 0;
    while (lat < 100) begin
      #1;
      if (stall) stalls++;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (result_valid) break;
    end
    res = result;
  endtask

  initial begin
    int lat, stalls, cnt;
    logic [31:0] res;

    reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = OP_MUL; in_a = '0; in_b = '0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    check("reset_result", result, 0);
    check("reset_stall", stall, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[2]  = '{OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 34};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,        32'd14,       34};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,        32'd2,        34};
    vecs[8]  = '{OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{OP_REM,    32'd5,          32'd0,        32'd5,        1};
    vecs[10] = '{OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{OP_MUL,    32'd123456,     32'd1000,     32'd123456000, 34};

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, stalls, res);
      check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_stall_cycles", i), stalls, vecs[i].exp_lat);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid_one_cycle", i), result_valid, 0);
    end

    // Establish a known held result, then flush mid-CALC.
    do_op(OP_DIVU, 32'd100, 32'd7, lat, stalls, res);
    check("pre_flush_result", res, 14);
    op = OP_MULHU; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_stall", stall, 0);
    check("flush_valid", result_valid, 0);
    check("flush_result_held", result, 14);
    cnt = 0;
    repeat (40) begin @(posedge clk); #1; if (result_valid) cnt++; end
    check("flush_no_valid_later", cnt, 0);

    // Flush with start in the same cycle: start is dropped.
    op = OP_MUL; in_a = 32'd3; in_b = 32'd4; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);
    check("flush_start_valid", result_valid, 0);

    // Asynchronous reset in the middle of CALC.
    op = OP_MUL; in_a = 32'd3; in_b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", result_valid, 0);
    check("rst_mid_result", result, 0);
    check("rst_mid_stall", stall, 0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: new start in DONE, with ignored start pulses during CALC.
    do_op(OP_DIVU, 32'd100, 32'd7, lat, stalls, res);
    check("b2b_first_valid", result_valid, 1);
    check("b2b_first_result", res, 14);
    op = OP_MUL; in_a = 32'd3; in_b = 32'd4; start = 1'b1;
    #1;
    check("b2b_stall_in_done", stall, 1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check("b2b_not_special", result_valid, 0);
    while (!result_valid && lat < 100) begin
      if (lat == 5 || lat == 20) begin
        start = 1'b1; op = OP_DIVU; in_a = 32'd1; in_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("b2b_latency", lat, 34);
    check("b2b_result", result, 12);
    @(posedge clk); #1;
    check("b2b_valid_drop", result_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
